pumpkin_cpu_top: RTL and testbench



---
 rtl/pumpkin_cpu_top_pkg.sv | 20 ++
 rtl/pumpkin_cpu_top_if.sv | 27 ++
 rtl/pumpkin_cpu_top_branch_decode.sv | 17 +
 rtl/pumpkin_cpu_top.sv | 81 ++++++++
 tb/tb_pumpkin_cpu_top.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pumpkin_cpu_top_pkg.sv
// Shared constants for the pumpkin front end: bus widths, FSM encodings and
// the unconditional-branch opcode.
package pumpkin_cpu_top_pkg;

  localparam int CPU_WORD_LEN_IN_BITS           = 64;
  localparam int OFF_CORE_ACCESS_WIDTH_IN_BITS  = 128;
  localparam int BYTE_LEN_IN_BITS               = 8;
  localparam int OFF_CORE_ACCESS_WIDTH_IN_BYTES = OFF_CORE_ACCESS_WIDTH_IN_BITS / BYTE_LEN_IN_BITS;
  localparam int INSTR_LEN_IN_BITS              = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_EXEC = 2'd3;

  localparam logic [5:0] B_OPCODE = 6'b000101;

  typedef logic [INSTR_LEN_IN_BITS-1:0] instr_t;

endpackage

// File: rtl/pumpkin_cpu_top_if.sv
// Off-core fetch handshake: line-aligned address strobe out, payload + ready level in.
interface pumpkin_cpu_top_if #(
  parameter int ADDR_W = pumpkin_cpu_top_pkg::CPU_WORD_LEN_IN_BITS,
  parameter int DATA_W = pumpkin_cpu_top_pkg::OFF_CORE_ACCESS_WIDTH_IN_BITS
);
  logic [DATA_W-1:0] off_core_access_payload_inout;
  logic              off_core_access_ready_inout;
  logic [ADDR_W-1:0] off_core_access_addr_inout;
  logic              off_core_access_addr_valid_inout;
  logic              off_core_access_is_write_out;

  modport master (
    input  off_core_access_payload_inout,
    input  off_core_access_ready_inout,
    output off_core_access_addr_inout,
    output off_core_access_addr_valid_inout,
    output off_core_access_is_write_out
  );

  modport slave (
    output off_core_access_payload_inout,
    output off_core_access_ready_inout,
    input  off_core_access_addr_inout,
    input  off_core_access_addr_valid_inout,
    input  off_core_access_is_write_out
  );
endinterface

// File: rtl/pumpkin_cpu_top_branch_decode.sv
// Next-PC computation: B (imm26 word offset, sign-extended) or fall-through PC+4.
module pumpkin_branch_decode #(
  parameter int W = pumpkin_cpu_top_pkg::CPU_WORD_LEN_IN_BITS
) (
  input  logic [31:0]  instr,
  input  logic [W-1:0] pc,
  output logic [W-1:0] next_pc,
  output logic         is_branch
);
  import pumpkin_cpu_top_pkg::*;

  logic [W-1:0] offset;

  assign is_branch = (instr[31:26] == B_OPCODE);
  assign offset    = {{(W-28){instr[25]}}, instr[25:0], 2'b00};
  assign next_pc   = pc + (is_branch ? offset : W'(4));
endmodule

// File: rtl/pumpkin_cpu_top.sv
// Pumpkin front end: fetches 16-byte lines, steps through their words and
// follows B branches, refetching only when the next PC leaves the held line.
module pumpkin_cpu_top #(
  parameter int CPU_WORD_LEN_IN_BITS          = pumpkin_cpu_top_pkg::CPU_WORD_LEN_IN_BITS,
  parameter int OFF_CORE_ACCESS_WIDTH_IN_BITS = pumpkin_cpu_top_pkg::OFF_CORE_ACCESS_WIDTH_IN_BITS,
  parameter logic [CPU_WORD_LEN_IN_BITS-1:0] RESET_VECTOR = '0
) (
  input  logic                            clk_in,
  input  logic                            reset_in,
  pumpkin_cpu_top_if.master               bus,
  output logic [CPU_WORD_LEN_IN_BITS-1:0] pc_out,
  output logic [31:0]                     instr_out,
  output logic                            instr_valid_out,
  output logic                            inout_ctrl_out
);
  import pumpkin_cpu_top_pkg::*;

  localparam int W          = CPU_WORD_LEN_IN_BITS;
  localparam int LINE_BYTES = OFF_CORE_ACCESS_WIDTH_IN_BITS / BYTE_LEN_IN_BITS;
  localparam int OFF_BITS   = $clog2(LINE_BYTES);
  localparam int SLOT_BITS  = OFF_BITS - 2;
  localparam logic [W-1:0] LINE_MASK = ~(W'(LINE_BYTES) - W'(1));

  logic [1:0]                               state;
  logic [W-1:0]                             pc;
  logic [W-1:0]                             tag;
  logic [OFF_CORE_ACCESS_WIDTH_IN_BITS-1:0] line_buf;

  logic [SLOT_BITS-1:0] slot;
  instr_t               cur_instr;
  logic [W-1:0]         next_pc;
  logic                 is_branch;
  logic                 leave_line;

  assign slot      = pc[OFF_BITS-1:2];
  assign cur_instr = line_buf[32*slot +: 32];

  pumpkin_branch_decode #(.W(W)) u_decode (
    .instr     (cur_instr),
    .pc        (pc),
    .next_pc   (next_pc),
    .is_branch (is_branch)
  );

  // Fall-through only leaves the line from the last slot; branches need the tag compare.
  assign leave_line = is_branch ? ((next_pc & LINE_MASK) != tag) : (slot == '1);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state    <= ST_IDLE;
      pc       <= RESET_VECTOR;
      tag      <= '0;
      line_buf <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ:  state <= ST_WAIT;
        // Capture only after the request edge, so a stale-high ready sees fresh payload.
        ST_WAIT: if (bus.off_core_access_ready_inout) begin
          line_buf <= bus.off_core_access_payload_inout;
          tag      <= pc & LINE_MASK;
          state    <= ST_EXEC;
        end
        ST_EXEC: begin
          pc <= next_pc;
          if (leave_line) state <= ST_REQ;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.off_core_access_addr_valid_inout = (state == ST_REQ);
  assign bus.off_core_access_addr_inout       = (state == ST_REQ) ? (pc & LINE_MASK) : '0;
  assign bus.off_core_access_is_write_out     = 1'b0;
  assign inout_ctrl_out                       = 1'b0;

  assign instr_valid_out = (state == ST_EXEC);
  assign instr_out       = (state == ST_EXEC) ? cur_instr : '0;
  assign pc_out          = (state == ST_EXEC) ? pc : '0;
endmodule

// File: tb/tb_pumpkin_cpu_top.sv
// Bench for pumpkin_cpu_top: byte-addressed memory responder plus an
// architectural PC/fetch model checked on every presented instruction.
module tb_pumpkin_cpu_top;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic [63:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid_out;
  logic        inout_ctrl_out;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [256];
  int         mem_delay = 0;
  int         dly_cnt = 0;

  pumpkin_cpu_top_if bus ();

  pumpkin_cpu_top dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .bus             (bus),
    .pc_out          (pc_out),
    .instr_out       (instr_out),
    .instr_valid_out (instr_valid_out),
    .inout_ctrl_out  (inout_ctrl_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    int b;
    b = int'({a[7:2], 2'b00});
    return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
  endfunction

  function automatic logic [127:0] mem_line(input logic [63:0] a);
    logic [127:0] d;
    int           b;
    b = int'({a[7:4], 4'h0});
    for (int i = 0; i < 16; i++) d[8*i +: 8] = mem[b+i];
    return d;
  endfunction

  // Architectural rule: B jumps by sign-extended imm26 words, everything else falls through.
  function automatic logic [63:0] ref_next(input logic [63:0] pc);
    logic [31:0] w;
    longint      off;
    w = mem_word(pc);
    if (w[31:26] == 6'b000101) begin
      off = longint'($signed(w[25:0])) * 4;
      return pc + 64'(off);
    end
    return pc + 64'd4;
  endfunction

  // Memory: payload registered on the request edge; ready is a level that may stay high.
  initial begin
    bus.off_core_access_payload_inout = '0;
    bus.off_core_access_ready_inout   = 1'b0;
  end
  always @(posedge clk_in) begin
    if (bus.off_core_access_addr_valid_inout) begin
      bus.off_core_access_payload_inout <= mem_line(bus.off_core_access_addr_inout);
      if (mem_delay == 0) bus.off_core_access_ready_inout <= 1'b1;
      else begin
        bus.off_core_access_ready_inout <= 1'b0;
        dly_cnt <= mem_delay;
      end
    end else if (dly_cnt > 0) begin
      dly_cnt <= dly_cnt - 1;
      if (dly_cnt == 1) bus.off_core_access_ready_inout <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a+i] = w[8*i +: 8];
  endtask

  task automatic fill_nop();
    for (int a = 0; a < 256; a += 4) set_word(a, NOP);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr_valid"}, 64'(bus.off_core_access_addr_valid_inout), 64'd0);
    chk({tag, "_addr"}, bus.off_core_access_addr_inout, 64'd0);
    chk({tag, "_instr_valid"}, 64'(instr_valid_out), 64'd0);
    chk({tag, "_instr"}, 64'(instr_out), 64'd0);
    chk({tag, "_pc"}, pc_out, 64'd0);
    chk({tag, "_is_write"}, 64'(bus.off_core_access_is_write_out), 64'd0);
    chk({tag, "_inout_ctrl"}, 64'(inout_ctrl_out), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_in);
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    chk_reset_outputs(tag);
    reset_in = 1'b0;
  endtask

  // Follow n presented instructions against the model, then confirm the request stream.
  task automatic run_trace(input int n, input string tag);
    logic [63:0] epc, nxt;
    logic [63:0] exp_req[$];
    logic [63:0] seen_req[$];
    int          got, cyc, nreq;
    bit          ctrl_bad;
    epc = 64'h0; got = 0; cyc = 0; ctrl_bad = 0;
    exp_req.push_back(64'h0);
    while (got < n && cyc < n * 12 + 60) begin
      @(negedge clk_in);
      cyc++;
      if (bus.off_core_access_is_write_out !== 1'b0 || inout_ctrl_out !== 1'b0) ctrl_bad = 1;
      if (bus.off_core_access_addr_valid_inout) seen_req.push_back(bus.off_core_access_addr_inout);
      if (instr_valid_out) begin
        chk($sformatf("%s_pc%0d", tag, got), pc_out, epc);
        chk($sformatf("%s_instr%0d", tag, got), 64'(instr_out), 64'(mem_word(epc)));
        nxt = ref_next(epc);
        if ((nxt >> 4) != (epc >> 4)) exp_req.push_back(nxt & ~64'hF);
        epc = nxt;
        got++;
      end
    end
    chk({tag, "_instr_count"}, 64'(got), 64'(n));
    repeat (2) begin
      @(negedge clk_in);
      if (bus.off_core_access_is_write_out !== 1'b0 || inout_ctrl_out !== 1'b0) ctrl_bad = 1;
      if (bus.off_core_access_addr_valid_inout) seen_req.push_back(bus.off_core_access_addr_inout);
    end
    chk({tag, "_req_count"}, 64'(seen_req.size()), 64'(exp_req.size()));
    nreq = (seen_req.size() < exp_req.size()) ? seen_req.size() : exp_req.size();
    for (int i = 0; i < nreq; i++)
      chk($sformatf("%s_req%0d", tag, i), seen_req[i], exp_req[i]);
    chk({tag, "_ctrl_zero"}, 64'(ctrl_bad), 64'd0);
  endtask

  initial begin
    logic [31:0] w;
    int          sel, imm;

    // Straight-line NOPs; second request sees a ready already high.
    fill_nop();
    mem_delay = 0;
    do_reset("rst0");
    run_trace(5, "nop");

    // B +12 from 0x4 lands in the next line.
    fill_nop();
    set_word(4, 32'h14000003);
    do_reset("rst1");
    run_trace(3, "b_fwd");

    // B -8 from 0x8 loops inside line 0.
    fill_nop();
    set_word(8, 32'h17FFFFFE);
    do_reset("rst2");
    run_trace(9, "b_back");

    // Branch to self.
    fill_nop();
    set_word(0, 32'h14000000);
    do_reset("rst3");
    run_trace(10, "b_self");

    // Distinct line 0 so a capture of the old payload would show at 0x10.
    fill_nop();
    for (int a = 0; a < 16; a += 4) set_word(a, 32'hAA000000 + 32'(a));
    do_reset("rst4");
    run_trace(5, "stale_rdy");

    // Reset in WAIT: slow memory, stop while the 0x10 request is pending.
    fill_nop();
    for (int a = 16; a < 32; a += 4) set_word(a, 32'hAB000000 + 32'(a));
    mem_delay = 8;
    do_reset("rst5");
    run_trace(4, "pre_wait");
    #2 reset_in = 1'b1;
    #1 chk_reset_outputs("mid_wait");
    repeat (12) @(negedge clk_in);
    mem_delay = 0;
    reset_in = 1'b0;
    run_trace(6, "post_wait");

    // Random programs: NOPs, non-branch words and short B offsets.
    for (int s = 0; s < 3; s++) begin
      for (int a = 0; a < 256; a += 4) begin
        sel = int'($urandom_range(0, 3));
        if (sel == 0) w = NOP;
        else if (sel == 1) begin
          w = $urandom;
          if (w[31:26] == 6'b000101) w[31] = 1'b1;
        end else begin
          imm = int'($urandom_range(0, 16)) - 8;
          w = {6'b000101, 26'(imm)};
        end
        set_word(a, w);
      end
      mem_delay = int'($urandom_range(0, 3));
      do_reset($sformatf("rst_rand%0d", s));
      run_trace(60, $sformatf("rand%0d", s));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
